// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, field positions and ExcCodes
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - prescaled Count/Compare timer with sticky TI
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_inc;

  // A Count write pre-empts the increment that would otherwise happen this cycle.
  assign tick      = ~count_we & (presc == PRESC_MAX);
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if (compare_we) compare <= wdata;

      // Clear wins over a same-cycle match.
      if (compare_we)                          ti <= 1'b0;
      else if (tick && count_inc == compare)   ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_gen2.sv
// rtl/cp0_gen2.sv - MIPS32 CP0 (Status/Cause/EPC/BadVAddr/Count/Compare); timer under CP0_TIMER_EN
module cp0_gen2
  import cp0_pkg::*;
#(
  parameter int NUM_HW_INT = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [4:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic                  bd,
  input  logic [31:0]           vpc,
  input  logic [31:0]           bad_vaddr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           epc_out,
  output logic                  exl_out,
  output logic                  int_req
);

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  sw_ip;
  logic [5:0]  hw_ip;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [7:0]  ip;

  logic wr, wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  // An exception taken this cycle drops the whole mtc0.
  assign wr         = we & ~exc_req;
  assign wr_status  = wr && (addr == CP0_STATUS);
  assign wr_cause   = wr && (addr == CP0_CAUSE);
  assign wr_epc     = wr && (addr == CP0_EPC);
  assign wr_count   = wr && (addr == CP0_COUNT);
  assign wr_compare = wr && (addr == CP0_COMPARE);

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  assign ip = {ti | hw_ip[5], hw_ip[4:0], sw_ip};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im         <= STATUS_RESET[ST_IM_LO +: 8];
      exl        <= STATUS_RESET[ST_EXL];
      ie         <= STATUS_RESET[ST_IE];
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      sw_ip      <= '0;
      hw_ip      <= '0;
      epc        <= '0;
      badvaddr   <= '0;
    end else begin
      hw_ip <= 6'(hw_int);

      if (wr_status) begin
        im <= wdata[ST_IM_LO +: 8];
        ie <= wdata[ST_IE];
      end
      if (wr_cause) sw_ip <= wdata[CA_IP_LO +: 2];
      if (wr_epc)   epc   <= wdata;

      if (exc_req) begin
        exl        <= 1'b1;
        exc_code_q <= exc_code;
        if (!exl) begin
          epc  <= bd ? vpc - 32'd4 : vpc;
          bd_q <= bd;
        end
        if (is_addr_exc(exc_code)) badvaddr <= bad_vaddr;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr_status) begin
        exl <= wdata[ST_EXL];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS: begin
        rdata[ST_BEV]         = STATUS_RESET[ST_BEV];
        rdata[ST_IM_LO +: 8]  = im;
        rdata[ST_EXL]         = exl;
        rdata[ST_IE]          = ie;
      end
      CP0_CAUSE: begin
        rdata[CA_BD]          = bd_q;
        rdata[CA_TI]          = ti;
        rdata[CA_IP_LO +: 8]  = ip;
        rdata[CA_EXC_LO +: 5] = exc_code_q;
      end
      CP0_EPC:      rdata = epc;
      default:      rdata = '0;
    endcase
  end

  assign epc_out = epc;
  assign exl_out = exl;
  assign int_req = ie & ~exl & |(ip & im);

endmodule

// File: tb/tb_cp0_gen2.sv
// tb/tb_cp0_gen2.sv - directed self-checking bench for cp0_gen2
module tb_cp0_gen2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        bd;
  logic [31:0] vpc;
  logic [31:0] bad_vaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic        exl_out;
  logic        int_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_gen2 #(.NUM_HW_INT(6), .COUNT_DIV(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .bd        (bd),
    .vpc       (vpc),
    .bad_vaddr (bad_vaddr),
    .eret      (eret),
    .hw_int    (hw_int),
    .epc_out   (epc_out),
    .exl_out   (exl_out),
    .int_req   (int_req)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic take_exc(input logic [4:0] code, input logic b, input logic [31:0] pc,
                          input logic [31:0] bv);
    exc_req = 1'b1; exc_code = code; bd = b; vpc = pc; bad_vaddr = bv;
    cycle();
    exc_req = 1'b0; bd = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0; addr = '0; wdata = '0; exc_req = 1'b0; exc_code = '0;
    bd = 1'b0; vpc = '0; bad_vaddr = '0; eret = 1'b0; hw_int = '0;
    cycle(); cycle();
    resetn = 1'b1;

    rd("rst_status", 5'd12, 32'h0040_0000);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_badvaddr", 5'd8, 32'h0);
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_compare", 5'd11, 32'h0);
    rd("unmapped_addr", 5'd20, 32'h0);
    chk("rst_int_req", {31'b0, int_req}, 32'd0);
    chk("rst_exl", {31'b0, exl_out}, 32'd0);
    chk("rst_epc_out", epc_out, 32'h0);

    // Hardware interrupt 0 through IM[2]
    mtc0(5'd12, 32'h0000_0401);
    rd("status_wr", 5'd12, 32'h0040_0401);
    hw_int = 6'h01;
    #1;
    chk("hw_int_latency", {31'b0, int_req}, 32'd0);
    cycle();
    rd("cause_ip2", 5'd13, 32'h0000_0400);
    chk("int_req_on", {31'b0, int_req}, 32'd1);

    take_exc(5'd0, 1'b0, 32'hBFC0_0100, 32'h0);
    chk("exc_exl", {31'b0, exl_out}, 32'd1);
    chk("exc_int_masked", {31'b0, int_req}, 32'd0);
    chk("exc_epc", epc_out, 32'hBFC0_0100);
    rd("exc_status", 5'd12, 32'h0040_0403);

    eret = 1'b1; cycle(); eret = 1'b0;
    chk("eret_exl", {31'b0, exl_out}, 32'd0);
    chk("eret_int_req", {31'b0, int_req}, 32'd1);
    hw_int = 6'h00;
    cycle();

    // Delay-slot AdEL then nested Ov
    take_exc(5'd4, 1'b1, 32'h8000_0014, 32'h8000_0003);
    chk("adel_epc", epc_out, 32'h8000_0010);
    rd("adel_cause", 5'd13, 32'h8000_0010);
    rd("adel_badvaddr", 5'd8, 32'h8000_0003);

    take_exc(5'd12, 1'b0, 32'h0000_1234, 32'h0000_FFFF);
    chk("nested_epc", epc_out, 32'h8000_0010);
    rd("nested_cause", 5'd13, 32'h8000_0030);
    rd("nested_badvaddr", 5'd8, 32'h8000_0003);
    chk("nested_exl", {31'b0, exl_out}, 32'd1);

    // eret together with a Status write that sets EXL: EXL still ends 0
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    eret = 1'b0;
    rd("eret_status_wr", 5'd12, 32'h0040_0401);
    chk("eret_status_exl", {31'b0, exl_out}, 32'd0);

    eret = 1'b1;
    mtc0(5'd14, 32'h0000_0055);
    eret = 1'b0;
    chk("eret_epc_wr", epc_out, 32'h0000_0055);

    // exc_req drops a same-cycle mtc0
    we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF;
    take_exc(5'd8, 1'b0, 32'h0000_0100, 32'h0);
    we = 1'b0;
    chk("exc_drops_mtc0", epc_out, 32'h0000_0100);

    // exc_req beats eret
    eret = 1'b1;
    take_exc(5'd8, 1'b0, 32'h0000_0200, 32'h0);
    eret = 1'b0;
    chk("exc_beats_eret", {31'b0, exl_out}, 32'd1);
    chk("exc_beats_eret_epc", epc_out, 32'h0000_0100);
    eret = 1'b1; cycle(); eret = 1'b0;

    // Software interrupts
    mtc0(5'd12, 32'h0000_0101);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_sw_ip", 5'd13, 32'h0000_0320);
    chk("sw_int_req", {31'b0, int_req}, 32'd1);
    mtc0(5'd12, 32'h0000_0100);
    chk("ie_off", {31'b0, int_req}, 32'd0);
    mtc0(5'd13, 32'h0000_0000);
    mtc0(5'd8, 32'h1111_1111);
    rd("badvaddr_ro", 5'd8, 32'h8000_0003);

    // hw_int[5] lands on IP[7]
    mtc0(5'd12, 32'h0000_8001);
    hw_int = 6'h20;
    cycle();
    rd("cause_ip7", 5'd13, 32'h0000_8020);
    chk("ip7_int_req", {31'b0, int_req}, 32'd1);
    hw_int = 6'h00;
    cycle();
    chk("ip7_off", {31'b0, int_req}, 32'd0);

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 9; i++) cycle();
    rd("ti_before", 5'd13, 32'h0000_0020);
    cycle();
    rd("ti_set", 5'd13, 32'h4000_8020);
    chk("ti_int_req", {31'b0, int_req}, 32'd1);
    rd("count_at_ti", 5'd9, 32'd5);
    mtc0(5'd11, 32'd7);
    rd("ti_cleared", 5'd13, 32'h0000_0020);
    chk("ti_clr_int_req", {31'b0, int_req}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd("count_loaded", 5'd9, 32'hFFFF_FFFF);
    cycle(); cycle();
    rd("count_wrap", 5'd9, 32'h0);
`else
    mtc0(5'd9, 32'h0000_1234);
    mtc0(5'd11, 32'h0000_0003);
    for (int i = 0; i < 12; i++) cycle();
    rd("count_absent", 5'd9, 32'h0);
    rd("compare_absent", 5'd11, 32'h0);
    rd("ti_absent", 5'd13, 32'h0000_0020);
`endif

    // Reset beats a same-cycle exception
    resetn = 1'b0;
    take_exc(5'd4, 1'b0, 32'h0000_0300, 32'h0000_0400);
    resetn = 1'b1;
    chk("reset_wins_exl", {31'b0, exl_out}, 32'd0);
    chk("reset_wins_epc", epc_out, 32'h0);
    rd("reset_wins_status", 5'd12, 32'h0040_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_gen2.md
Name: cp0_gen2

Overview:
- Parametrised second-generation coprocessor-0 for the MIPS32 core: Status, Cause, EPC, BadVAddr, Count and Compare registers.
- Adds a configurable hardware-interrupt count, software interrupts, a prescaled Count/Compare timer and nested-exception rules.
- Sits beside the CPU core inside mycpu_top. Serves mfc0/mtc0, records exception entry, clears EXL on eret, and raises the interrupt request back to the core.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines, 1..6; line i maps to Cause.IP[2+i].
- COUNT_DIV, 2, clock cycles per Count increment, >=1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- we  in  1  mtc0 write strobe.
- addr  in  5  CP0 register number.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data, combinational from current register state.
- exc_req  in  1  exception or interrupt being taken this cycle.
- exc_code  in  5  ExcCode of the taken exception.
- bd  in  1  victim instruction is in a delay slot.
- vpc  in  32  PC of the victim instruction.
- bad_vaddr  in  32  faulting address for AdEL/AdES.
- eret  in  1  eret committing.
- hw_int  in  NUM_HW_INT  level hardware interrupts.
- epc_out  out  32  current EPC.
- exl_out  out  1  current Status.EXL.
- int_req  out  1  pending enabled interrupt.

Behaviour:
- Register addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other address reads 0 and ignores writes.
- Reset (resetn=0 at a clk edge):
  - Status=0x0040_0000 (BEV=1); all other registers 0; prescaler 0.
  - Outputs after reset: int_req=0, exl_out=0, epc_out=0.
- Writable bits:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[1:0] (software interrupts) only.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only.
- Writes take effect at the next edge.
- Cause.IP[2+i] is a registered copy of hw_int[i], sampled every cycle. This gives 1 cycle of latency from hw_int to int_req.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Purely combinational from registers.
- Exception entry (exc_req=1):
  - If EXL was 0: EPC <= bd ? vpc-4 : vpc; Cause.BD <= bd.
  - If EXL was 1 (nested): EPC and BD are unchanged.
  - In both cases: EXL <= 1; Cause.ExcCode <= exc_code.
  - BadVAddr <= bad_vaddr only when exc_code is AdEL(4) or AdES(5).
- eret: EXL <= 0. All other state is unchanged.
- Simultaneous events:
  - exc_req beats eret.
  - exc_req suppresses the whole mtc0 write in that cycle.
  - eret and an mtc0 write to a register other than Status both apply.
  - eret with an mtc0 write to Status: the write applies, then EXL is forced to 0.
- Timer (only when CP0_TIMER_EN is defined):
  - Prescaler counts 0..COUNT_DIV-1. On wrap, Count increments, wrapping 0xFFFF_FFFF to 0.
  - A Count write loads Count and clears the prescaler.
  - When an increment makes Count == Compare, Cause.TI is set to 1. TI is sticky.
  - A Compare write clears TI; clear beats set in the same cycle.
  - IP[7] = TI | (NUM_HW_INT==6 ? sampled hw_int[5] : 0).
- Reset mid-operation wins over every event, including exc_req.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined:
  - Count and Compare read 0 and ignore writes; TI reads 0.
  - IP[7] carries only hw_int[5] (when present).
  - No prescaler logic is present.

Decomposition:
- Shared package `cp0_pkg`:
  - Register-number constants.
  - Status/Cause bit-position constants.
  - ExcCode constants: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - Status reset value.
- One natural sub-module: `cp0_timer`, containing the prescaler, Count, Compare and TI generation. It is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset → read Status = 0x0040_0000 and all other registers 0; int_req=0.
- mtc0 Status=0x0000_0401, then hw_int[0]=1 → Cause.IP[2]=1 one cycle later; int_req=1. Then exc_req with code 0 and vpc=0xBFC0_0100 → EXL=1, int_req=0, EPC=0xBFC0_0100. Then eret → EXL=0, int_req=1.
- Delay-slot AdEL: bd=1, vpc=0x8000_0014, bad_vaddr=0x8000_0003 → EPC=0x8000_0010, BD=1, ExcCode=4, BadVAddr=0x8000_0003.
- Nested exception with EXL=1: exc_req with vpc=0x1234, code 12 → EPC unchanged; ExcCode=12.
- Timer (COUNT_DIV=2, CP0_TIMER_EN defined): write Compare=5, Count=0 → TI sets exactly 10 cycles after the Count write. Then write Compare → TI clears. Also load Count=0xFFFF_FFFF → Count reads 0 after 2 cycles.
- Same-cycle exc_req with mtc0 EPC=0xDEAD_BEEF and vpc=0x100 → EPC=0x100 (write dropped).
